ring_arbiter: RTL and testbench

- Packet-level arbiter that merges forwarded ring traffic and locally injected traffic onto one debug-ring output link.
- Sits inside each ring router stage, in front of the ring output port. It shares the single output link between two requesters: the ring input and the local module input.
- Ring traffic has default priority. A fairness counter guarantees the local port one packet after MAX_RING_PKTS consecutive ring packets have been granted while local was waiting.
- Output is registered: one flit slot, 1-cycle latency.

---
 rtl/ring_arbiter.sv | 106 ++++++++++
 tb/tb_ring_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ring_arbiter.sv
// Two-input packet arbiter for a debug-ring router stage: forwarded ring traffic
// has priority, local injection is guaranteed a packet after MAX_RING_PKTS ring packets.
package ring_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module ring_arbiter
    import ring_arbiter_pkg::*;
#(
    parameter int MAX_RING_PKTS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  dii_flit    ring_in,
    output logic       ring_in_ready,
    input  dii_flit    local_in,
    output logic       local_in_ready,
    output dii_flit    out,
    input  logic       out_ready,
    output logic [1:0] grant
);

    localparam int CNT_W = $clog2(MAX_RING_PKTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RING_PKTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RING  = 2'd1,
        LOCAL = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sel_ring;
    logic             sel_local;
    logic             slot_free;
    logic             acc_ring;
    logic             acc_local;

    always_comb begin
        sel_ring  = 1'b0;
        sel_local = 1'b0;
        case (state)
            IDLE: begin
                sel_local = local_in.valid && (!ring_in.valid || cnt == CNT_MAX);
                sel_ring  = ring_in.valid && !sel_local;
            end
            RING:    sel_ring  = 1'b1;
            LOCAL:   sel_local = 1'b1;
            default: ;
        endcase
    end

    // While reset is held nothing is offered or accepted, so grant reads idle.
    assign slot_free      = !out.valid || out_ready;
    assign ring_in_ready  = rst && sel_ring && slot_free;
    assign local_in_ready = rst && sel_local && slot_free;
    assign grant          = rst ? {sel_local, sel_ring} : 2'b00;
    assign acc_ring       = ring_in_ready && ring_in.valid;
    assign acc_local      = local_in_ready && local_in.valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out   <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            if (acc_ring) begin
                out <= ring_in;
            end else if (acc_local) begin
                out <= local_in;
            end else if (out_ready) begin
                out.valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (acc_ring) begin
                        // Count only ring packets that made local wait; saturate, never wrap.
                        if (!local_in.valid) begin
                            cnt <= '0;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (!ring_in.last) state <= RING;
                    end else if (acc_local) begin
                        cnt <= '0;
                        if (!local_in.last) state <= LOCAL;
                    end
                end
                RING: begin
                    if (acc_ring && ring_in.last) state <= IDLE;
                end
                LOCAL: begin
                    if (acc_local && local_in.last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed vector bench for ring_arbiter (MAX_RING_PKTS = 4): table-driven cycle
// vectors plus a hand-written asynchronous mid-packet reset sequence.
module tb_ring_arbiter;
    import ring_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    dii_flit    ring_in;
    dii_flit    local_in;
    dii_flit    out;
    logic       ring_in_ready;
    logic       local_in_ready;
    logic       out_ready;
    logic [1:0] grant;

    int n_cmp = 0;
    int n_err = 0;

    ring_arbiter #(.MAX_RING_PKTS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ring_in        (ring_in),
        .ring_in_ready  (ring_in_ready),
        .local_in       (local_in),
        .local_in_ready (local_in_ready),
        .out            (out),
        .out_ready      (out_ready),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv, rl;
        logic [15:0] rd;
        logic        lv, ll;
        logic [15:0] ld;
        logic        ordy;
        logic        e_rr, e_lr;
        logic [1:0]  e_g;
        logic        e_ov;
        logic [15:0] e_od;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic rl, input logic [15:0] rd,
                       input logic lv, input logic ll, input logic [15:0] ld,
                       input logic ordy, input logic e_rr, input logic e_lr,
                       input logic [1:0] e_g, input logic e_ov, input logic [15:0] e_od);
        vec_t v;
        v = '{rv:rv, rl:rl, rd:rd, lv:lv, ll:ll, ld:ld, ordy:ordy,
              e_rr:e_rr, e_lr:e_lr, e_g:e_g, e_ov:e_ov, e_od:e_od};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic rl, input logic [15:0] rd,
                         input logic lv, input logic ll, input logic [15:0] ld,
                         input logic ordy);
        ring_in   = '{valid:rv, last:rl, data:rd};
        local_in  = '{valid:lv, last:ll, data:ld};
        out_ready = ordy;
    endtask

    initial begin
        drive(0, 0, 16'h0, 0, 0, 16'h0, 1);

        // ring only, 3-flit packet
        add(1,0,16'hA001, 0,0,16'h0, 1,  1,0,2'b01, 1,16'hA001);
        add(1,0,16'hA002, 0,0,16'h0, 1,  1,0,2'b01, 1,16'hA002);
        add(1,1,16'hA003, 0,0,16'h0, 1,  1,0,2'b01, 1,16'hA003);
        add(0,0,16'h0,    0,0,16'h0, 1,  0,0,2'b00, 0,16'h0);
        // both valid single-flit: R,R,R,R,L,R,R,R,R,L
        add(1,1,16'hB001, 1,1,16'hC001, 1, 1,0,2'b01, 1,16'hB001);
        add(1,1,16'hB002, 1,1,16'hC001, 1, 1,0,2'b01, 1,16'hB002);
        add(1,1,16'hB003, 1,1,16'hC001, 1, 1,0,2'b01, 1,16'hB003);
        add(1,1,16'hB004, 1,1,16'hC001, 1, 1,0,2'b01, 1,16'hB004);
        add(1,1,16'hB005, 1,1,16'hC001, 1, 0,1,2'b10, 1,16'hC001);
        add(1,1,16'hB005, 1,1,16'hC002, 1, 1,0,2'b01, 1,16'hB005);
        add(1,1,16'hB006, 1,1,16'hC002, 1, 1,0,2'b01, 1,16'hB006);
        add(1,1,16'hB007, 1,1,16'hC002, 1, 1,0,2'b01, 1,16'hB007);
        add(1,1,16'hB008, 1,1,16'hC002, 1, 1,0,2'b01, 1,16'hB008);
        add(1,1,16'hB009, 1,1,16'hC002, 1, 0,1,2'b10, 1,16'hC002);
        add(0,0,16'h0,    0,0,16'h0,    1, 0,0,2'b00, 0,16'h0);
        // local 4-flit packet, ring arrives mid-packet, one local bubble
        add(0,0,16'h0,    1,0,16'hD001, 1, 0,1,2'b10, 1,16'hD001);
        add(1,1,16'hE001, 1,0,16'hD002, 1, 0,1,2'b10, 1,16'hD002);
        add(1,1,16'hE001, 0,0,16'h0,    1, 0,1,2'b10, 0,16'h0);
        add(1,1,16'hE001, 1,0,16'hD003, 1, 0,1,2'b10, 1,16'hD003);
        add(1,1,16'hE001, 1,1,16'hD004, 1, 0,1,2'b10, 1,16'hD004);
        add(1,1,16'hE001, 0,0,16'h0,    1, 1,0,2'b01, 1,16'hE001);
        // 5-cycle output stall inside a ring packet
        add(1,0,16'hF001, 0,0,16'h0,    1, 1,0,2'b01, 1,16'hF001);
        for (int i = 0; i < 5; i++)
            add(1,0,16'hF002, 1,1,16'h6001, 0, 0,0,2'b01, 1,16'hF001);
        add(1,0,16'hF002, 1,1,16'h6001, 1, 1,0,2'b01, 1,16'hF002);
        add(1,1,16'hF003, 0,0,16'h0,    1, 1,0,2'b01, 1,16'hF003);
        add(0,0,16'h0,    0,0,16'h0,    1, 0,0,2'b00, 0,16'h0);
        // saturate cnt, then local alone is granted and cnt clears
        add(1,1,16'h7001, 1,1,16'h8001, 1, 1,0,2'b01, 1,16'h7001);
        add(1,1,16'h7002, 1,1,16'h8001, 1, 1,0,2'b01, 1,16'h7002);
        add(1,1,16'h7003, 1,1,16'h8001, 1, 1,0,2'b01, 1,16'h7003);
        add(1,1,16'h7004, 1,1,16'h8001, 1, 1,0,2'b01, 1,16'h7004);
        add(0,0,16'h0,    1,1,16'h8001, 1, 0,1,2'b10, 1,16'h8001);
        add(1,1,16'h7005, 1,1,16'h8002, 1, 1,0,2'b01, 1,16'h7005);
        add(0,0,16'h0,    0,0,16'h0,    1, 0,0,2'b00, 0,16'h0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst out.valid", 16'(out.valid), 16'h0);
        chk("rst out.data", out.data, 16'h0);
        chk("rst grant", 16'(grant), 16'h0);
        chk("rst rdy", 16'({ring_in_ready, local_in_ready}), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rv, vecs[k].rl, vecs[k].rd, vecs[k].lv, vecs[k].ll, vecs[k].ld, vecs[k].ordy);
            #1;
            chk($sformatf("v%0d ring_in_ready", k), 16'(ring_in_ready), 16'(vecs[k].e_rr));
            chk($sformatf("v%0d local_in_ready", k), 16'(local_in_ready), 16'(vecs[k].e_lr));
            chk($sformatf("v%0d grant", k), 16'(grant), 16'(vecs[k].e_g));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out.valid", k), 16'(out.valid), 16'(vecs[k].e_ov));
            if (vecs[k].e_ov)
                chk($sformatf("v%0d out.data", k), out.data, vecs[k].e_od);
        end

        // async reset mid-packet with cnt at its limit
        @(negedge clk); drive(1,1,16'h9000, 0,0,16'h0, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); drive(1,1,16'(16'h9000 + i), 1,1,16'h5001, 1);
        end
        @(negedge clk); drive(1,0,16'h9101, 1,1,16'h5001, 1);
        @(negedge clk); drive(1,0,16'h9102, 1,1,16'h5001, 1);
        #1;
        chk("lock ring_in_ready", 16'(ring_in_ready), 16'h1);
        chk("lock local_in_ready", 16'(local_in_ready), 16'h0);
        @(posedge clk);
        #1;
        chk("pre-rst out.data", out.data, 16'h9102);
        #2 rst = 1'b0;
        #1;
        chk("async rst out.valid", 16'(out.valid), 16'h0);
        chk("async rst grant", 16'(grant), 16'h0);
        chk("async rst rdy", 16'({ring_in_ready, local_in_ready}), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1,1,16'h9201, 1,1,16'h5002, 1);
        #1;
        chk("post-rst ring_in_ready", 16'(ring_in_ready), 16'h1);
        chk("post-rst grant", 16'(grant), 16'h1);
        @(posedge clk);
        #1;
        chk("post-rst out.data", out.data, 16'h9201);
        chk("post-rst out.valid", 16'(out.valid), 16'h1);
        @(negedge clk); drive(0,0,16'h0, 1,1,16'h5002, 1);
        #1;
        chk("post-rst local_in_ready", 16'(local_in_ready), 16'h1);
        @(posedge clk);
        #1;
        chk("post-rst local out.data", out.data, 16'h5002);
        @(negedge clk); drive(0,0,16'h0, 0,0,16'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
